// File: rtl/cache_set_ctrl_if.sv
// ----------------------------------------------------------------------------
// cache_set_ctrl_if
//   Groups the command/response handshake with the front end and the
//   request/acknowledge handshake with the next cache level.
//
//   Parameters: ADDR_W (address width), WAYS (associativity, sets resp_way width)
//
//   Signals:
//     req_valid/req_ready/req_cmd/req_addr   command handshake from the front end
//     resp_valid/resp_hit/resp_way/resp_mesi one-cycle completion report
//     mem_rd/mem_wb/mem_inv/mem_addr          next-level request, held until mem_ack
//     mem_ack/mem_shared                      next-level completion and fill sharing
//
//   Modports: slave  = the directory controller
//             master = the environment (front end plus next level)
// ----------------------------------------------------------------------------
interface cache_set_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int WAYS   = 8
);
  localparam int WAY_W = $clog2(WAYS);

  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;

  logic              resp_valid;
  logic              resp_hit;
  logic [WAY_W-1:0]  resp_way;
  logic [1:0]        resp_mesi;

  logic              mem_rd;
  logic              mem_wb;
  logic              mem_inv;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_shared;

  modport slave (
    input  req_valid, req_cmd, req_addr, mem_ack, mem_shared,
    output req_ready, resp_valid, resp_hit, resp_way, resp_mesi,
           mem_rd, mem_wb, mem_inv, mem_addr
  );

  modport master (
    output req_valid, req_cmd, req_addr, mem_ack, mem_shared,
    input  req_ready, resp_valid, resp_hit, resp_way, resp_mesi,
           mem_rd, mem_wb, mem_inv, mem_addr
  );
endinterface

// File: rtl/cache_set_ctrl.sv
// ----------------------------------------------------------------------------
// cache_set_ctrl
//   N-way set-associative cache directory controller. Holds tag, MESI state
//   and a true-LRU rank per line, performs hit lookup, picks a victim
//   (first invalid way, else the least recently used), writes back dirty
//   victims, fills from the next level and handles bus upgrades and snoops.
//
//   Parameters: WAYS, SETS, ADDR_W, OFFSET_W (see derived IDX_W/TAG_W/WAY_W)
//
//   Ports:
//     clk     clock
//     rst_n   asynchronous active-low reset (clears the whole directory)
//     bus     cache_set_ctrl_if.slave: request/response and next-level signals
//
//   Optional build macro CACHE_STATS_EN adds saturating 32-bit counters
//   stat_reads, stat_writes, stat_hits, stat_misses.
//
//   Commands: 0 read, 1 write, 2 ifetch, 3 snoop invalidate, 4 snoop read,
//             8 clear all. Any other code completes as a no-op miss.
// ----------------------------------------------------------------------------
module cache_set_ctrl #(
  parameter int WAYS     = 8,
  parameter int SETS     = 16384,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  cache_set_ctrl_if.slave    bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]        stat_reads,
  output logic [31:0]        stat_writes,
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_misses
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFFSET_W;
  localparam int WAY_W = $clog2(WAYS);

  localparam logic [3:0] CMD_READ    = 4'd0;
  localparam logic [3:0] CMD_WRITE   = 4'd1;
  localparam logic [3:0] CMD_IFETCH  = 4'd2;
  localparam logic [3:0] CMD_SNP_INV = 4'd3;
  localparam logic [3:0] CMD_SNP_RD  = 4'd4;
  localparam logic [3:0] CMD_CLEAR   = 4'd8;

  typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_e;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FETCH, UPG, RESP, CLEAR} state_e;

  // Directory storage
  mesi_e            mesi_mem [SETS][WAYS];
  logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
  logic [WAY_W-1:0] lru_mem  [SETS][WAYS];

  // Control state
  state_e           state_q, state_d;
  logic [3:0]       cmd_q;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q, idx_d;          // request set; also the CLEAR sweep counter
  logic [WAY_W-1:0] way_q, way_d;          // way being hit, filled or written back
  logic [TAG_W-1:0] victim_tag_q, victim_tag_d;
  logic             resp_hit_q, resp_hit_d;
  mesi_e            resp_mesi_q, resp_mesi_d;

  logic accept;
  logic proc_cmd;
  assign accept   = (state_q == IDLE) && bus.req_valid;
  assign proc_cmd = (cmd_q == CMD_READ) || (cmd_q == CMD_WRITE) || (cmd_q == CMD_IFETCH);

  // The line offset never reaches the directory.
  logic unused_offset;
  assign unused_offset = ^bus.req_addr[OFFSET_W-1:0];

  // --------------------------------------------------------------------------
  // Set lookup: hit way, first invalid way and LRU way of the latched set.
  // Scanning from the top down leaves the lowest matching index.
  // --------------------------------------------------------------------------
  logic             hit_any, free_any;
  logic [WAY_W-1:0] hit_way, free_way, lru_way, victim_way;
  mesi_e            hit_mesi;

  always_comb begin
    hit_any  = 1'b0;
    free_any = 1'b0;
    hit_way  = '0;
    free_way = '0;
    lru_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mesi_mem[idx_q][w] != MESI_I && tag_mem[idx_q][w] == tag_q) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (mesi_mem[idx_q][w] == MESI_I) begin
        free_any = 1'b1;
        free_way = WAY_W'(w);
      end
      if (lru_mem[idx_q][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    hit_mesi   = mesi_mem[idx_q][hit_way];
    victim_way = free_any ? free_way : lru_way;
  end

  // --------------------------------------------------------------------------
  // Next-state and directory write strobes
  // --------------------------------------------------------------------------
  logic             mesi_we, tag_we, lru_touch, clear_set;
  mesi_e            mesi_wdata;
  logic [WAY_W-1:0] wr_way;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    way_d        = way_q;
    victim_tag_d = victim_tag_q;
    resp_hit_d   = resp_hit_q;
    resp_mesi_d  = resp_mesi_q;
    mesi_we      = 1'b0;
    mesi_wdata   = MESI_I;
    tag_we       = 1'b0;
    lru_touch    = 1'b0;
    clear_set    = 1'b0;
    wr_way       = way_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = bus.req_addr[OFFSET_W +: IDX_W];
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        resp_hit_d  = 1'b0;
        resp_mesi_d = MESI_I;
        way_d       = '0;
        wr_way      = hit_way;
        state_d     = RESP;
        if (cmd_q == CMD_CLEAR) begin
          idx_d   = '0;
          state_d = CLEAR;
        end else if (proc_cmd) begin
          if (hit_any) begin
            resp_hit_d  = 1'b1;
            way_d       = hit_way;
            resp_mesi_d = hit_mesi;
            lru_touch   = 1'b1;
            if (cmd_q == CMD_WRITE) begin
              if (hit_mesi == MESI_S) begin
                state_d = UPG;
              end else begin
                mesi_we     = 1'b1;
                mesi_wdata  = MESI_M;
                resp_mesi_d = MESI_M;
              end
            end
          end else begin
            // LRU is updated when the fill lands, not here.
            way_d        = victim_way;
            victim_tag_d = tag_mem[idx_q][victim_way];
            state_d      = (mesi_mem[idx_q][victim_way] == MESI_M) ? WB : FETCH;
          end
        end else if (cmd_q == CMD_SNP_INV || cmd_q == CMD_SNP_RD) begin
          if (hit_any) begin
            resp_hit_d   = 1'b1;
            way_d        = hit_way;
            victim_tag_d = tag_q;
            if (hit_mesi == MESI_M) begin
              state_d = WB;
            end else begin
              mesi_we     = 1'b1;
              mesi_wdata  = (cmd_q == CMD_SNP_INV) ? MESI_I : MESI_S;
              resp_mesi_d = mesi_wdata;
            end
          end
        end
      end

      WB: begin
        if (bus.mem_ack) begin
          if (cmd_q == CMD_SNP_INV || cmd_q == CMD_SNP_RD) begin
            mesi_we     = 1'b1;
            mesi_wdata  = (cmd_q == CMD_SNP_INV) ? MESI_I : MESI_S;
            resp_mesi_d = mesi_wdata;
            state_d     = RESP;
          end else begin
            state_d = FETCH;
          end
        end
      end

      FETCH: begin
        if (bus.mem_ack) begin
          tag_we      = 1'b1;
          mesi_we     = 1'b1;
          mesi_wdata  = (cmd_q == CMD_WRITE) ? MESI_M : (bus.mem_shared ? MESI_S : MESI_E);
          resp_mesi_d = mesi_wdata;
          lru_touch   = 1'b1;
          state_d     = RESP;
        end
      end

      UPG: begin
        if (bus.mem_ack) begin
          mesi_we     = 1'b1;
          mesi_wdata  = MESI_M;
          resp_mesi_d = MESI_M;
          state_d     = RESP;
        end
      end

      CLEAR: begin
        clear_set = 1'b1;
        if (idx_q == IDX_W'(SETS - 1)) state_d = RESP;
        else                           idx_d   = idx_q + IDX_W'(1);
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      tag_q        <= '0;
      idx_q        <= '0;
      way_q        <= '0;
      victim_tag_q <= '0;
      resp_hit_q   <= 1'b0;
      resp_mesi_q  <= MESI_I;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      way_q        <= way_d;
      victim_tag_q <= victim_tag_d;
      resp_hit_q   <= resp_hit_d;
      resp_mesi_q  <= resp_mesi_d;
      if (accept) begin
        cmd_q <= bus.req_cmd;
        tag_q <= bus.req_addr[ADDR_W-1 -: TAG_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directory storage. True LRU: touching way h with rank L ages every way
  // ranked below L by one and makes h the most recent, keeping a permutation.
  // --------------------------------------------------------------------------
  // NOTE: the directory is reset along with the control flops because a reset
  // mid-operation must leave every line invalid with LRU rank equal to its way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          mesi_mem[s][w] <= MESI_I;
          tag_mem[s][w]  <= '0;
          lru_mem[s][w]  <= WAY_W'(w);
        end
      end
    end else if (clear_set) begin
      for (int w = 0; w < WAYS; w++) begin
        mesi_mem[idx_q][w] <= MESI_I;
        lru_mem[idx_q][w]  <= WAY_W'(w);
      end
    end else begin
      if (mesi_we) mesi_mem[idx_q][wr_way] <= mesi_wdata;
      if (tag_we)  tag_mem[idx_q][wr_way]  <= tag_q;
      if (lru_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == wr_way)
            lru_mem[idx_q][w] <= '0;
          else if (lru_mem[idx_q][w] < lru_mem[idx_q][wr_way])
            lru_mem[idx_q][w] <= lru_mem[idx_q][w] + WAY_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: next-level requests follow the state, so reset drops them at once.
  // --------------------------------------------------------------------------
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_way   = way_q;
  assign bus.resp_mesi  = resp_mesi_q;
  assign bus.mem_rd     = (state_q == FETCH);
  assign bus.mem_wb     = (state_q == WB);
  assign bus.mem_inv    = (state_q == UPG);

  always_comb begin
    bus.mem_addr = '0;
    case (state_q)
      WB:         bus.mem_addr = {victim_tag_q, idx_q, {OFFSET_W{1'b0}}};
      FETCH, UPG: bus.mem_addr = {tag_q, idx_q, {OFFSET_W{1'b0}}};
      default:    bus.mem_addr = '0;
    endcase
  end

`ifdef CACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state_q == LOOKUP) begin
      if (cmd_q == CMD_CLEAR) begin
        stat_reads  <= '0;
        stat_writes <= '0;
        stat_hits   <= '0;
        stat_misses <= '0;
      end else if (proc_cmd) begin
        if (cmd_q == CMD_WRITE) stat_writes <= sat_inc(stat_writes);
        else                    stat_reads  <= sat_inc(stat_reads);
        if (hit_any)            stat_hits   <= sat_inc(stat_hits);
        else                    stat_misses <= sat_inc(stat_misses);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_set_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cache_set_ctrl
//   Directed bench for cache_set_ctrl with WAYS=8, SETS=16 (IDX_W=4,
//   TAG_W=22): address = tag<<10 | set<<6. Expected values are worked out
//   by hand in the comments of each step.
// ----------------------------------------------------------------------------
module tb_cache_set_ctrl;
  localparam int WAYS     = 8;
  localparam int SETS     = 16;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 6;

  localparam logic [3:0] C_READ    = 4'd0;
  localparam logic [3:0] C_WRITE   = 4'd1;
  localparam logic [3:0] C_SNP_INV = 4'd3;
  localparam logic [3:0] C_SNP_RD  = 4'd4;
  localparam logic [3:0] C_CLEAR   = 4'd8;

  // {mem_rd, mem_wb, mem_inv}
  localparam logic [2:0] K_RD  = 3'b100;
  localparam logic [2:0] K_WB  = 3'b010;
  localparam logic [2:0] K_INV = 3'b001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cycle_cnt = 0;
  int   t_acc = 0;

  cache_set_ctrl_if #(.ADDR_W(ADDR_W), .WAYS(WAYS)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_hits, stat_misses;
`endif

  cache_set_ctrl #(
    .WAYS(WAYS), .SETS(SETS), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CACHE_STATS_EN
    ,
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one command for a single accepting cycle. Called and returns at posedge+1.
  task automatic issue(input string tag, input logic [3:0] cmd, input logic [31:0] addr);
    int n = 0;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_addr  = addr;
    t_acc = cycle_cnt;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Wait for a next-level request, check its kind and address, acknowledge it
  // in the same cycle it is first seen.
  task automatic serve_mem(input string tag, input logic [2:0] kind,
                           input logic [31:0] addr, input logic shared);
    int n = 0;
    while ({bus.mem_rd, bus.mem_wb, bus.mem_inv} == 3'b000 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_kind"}, {bus.mem_rd, bus.mem_wb, bus.mem_inv}, kind);
    check({tag, "_addr"}, bus.mem_addr, addr);
    if (n < 50) begin
      bus.mem_ack    = 1'b1;
      bus.mem_shared = shared;
      @(posedge clk); #1;
      bus.mem_ack    = 1'b0;
      bus.mem_shared = 1'b0;
    end
  endtask

  // Wait for the completion pulse and check it. lat > 0 checks the cycle
  // count with the accept cycle counted as 1; quiet checks that no next-level
  // request appeared while waiting.
  task automatic expect_resp(input string tag, input logic hit, input logic [2:0] way,
                             input logic [1:0] mesi, input int lat, input logic quiet);
    int   n = 0;
    logic mem_seen = 1'b0;
    while (!bus.resp_valid && n < 200) begin
      mem_seen = mem_seen | bus.mem_rd | bus.mem_wb | bus.mem_inv;
      @(posedge clk); #1; n++;
    end
    check({tag, "_valid"}, bus.resp_valid, 1);
    check({tag, "_hit"},   bus.resp_hit, hit);
    check({tag, "_way"},   bus.resp_way, way);
    check({tag, "_mesi"},  bus.resp_mesi, mesi);
    if (lat > 0) check({tag, "_latency"}, cycle_cnt - t_acc + 1, lat);
    if (quiet)   check({tag, "_no_mem"}, mem_seen, 0);
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, bus.resp_valid, 0);
  endtask

  initial begin
    int n;
    bus.req_valid  = 1'b0;
    bus.req_cmd    = '0;
    bus.req_addr   = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_shared = 1'b0;

    // Reset values while rst_n is low
    #12;
    check("rst_ready", bus.req_ready, 1);
    check("rst_flags", {bus.resp_valid, bus.resp_hit, bus.mem_rd, bus.mem_wb, bus.mem_inv}, 0);
    check("rst_way_mesi", {bus.resp_way, bus.resp_mesi}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold read 0x40 (set 1, tag 0): all ways invalid -> way 0, fill E.
    // Accept, LOOKUP, FETCH (ack in first cycle), RESP -> 4 cycles.
    issue("rd_cold", C_READ, 32'h0000_0040);
    serve_mem("rd_cold", K_RD, 32'h0000_0040, 1'b0);
    expect_resp("rd_cold", 1'b0, 3'd0, 2'd2, 4, 1'b0);

    // Same read hits: way 0, E, 3 cycles, no next-level traffic
    issue("rd_hit", C_READ, 32'h0000_0040);
    expect_resp("rd_hit", 1'b1, 3'd0, 2'd2, 3, 1'b1);

    // Write to the E line: silent E -> M
    issue("wr_e", C_WRITE, 32'h0000_0040);
    expect_resp("wr_e", 1'b1, 3'd0, 2'd3, 3, 1'b1);

    // Shared fill of 0x1480 (set 2, tag 5) -> S, then write needs an upgrade
    issue("rd_shared", C_READ, 32'h0000_1480);
    serve_mem("rd_shared", K_RD, 32'h0000_1480, 1'b1);
    expect_resp("rd_shared", 1'b0, 3'd0, 2'd1, 0, 1'b0);
    issue("wr_s", C_WRITE, 32'h0000_1480);
    serve_mem("wr_s", K_INV, 32'h0000_1480, 1'b0);
    expect_resp("wr_s", 1'b1, 3'd0, 2'd3, 0, 1'b0);
    issue("rd_after_upg", C_READ, 32'h0000_1480);
    expect_resp("rd_after_upg", 1'b1, 3'd0, 2'd3, 3, 1'b1);

    // Tags 1..7 into set 1 fill ways 1..7 in order. LRU ranks end [7,6,...,0],
    // so dirty tag 0 in way 0 is the LRU line.
    for (int t = 1; t < 8; t++) begin
      issue("fill_set1", C_READ, 32'h0000_0040 + t * 32'h400);
      serve_mem("fill_set1", K_RD, 32'h0000_0040 + t * 32'h400, 1'b0);
      expect_resp("fill_set1", 1'b0, 3'(t), 2'd2, 0, 1'b0);
    end

    // 9th tag (8 -> 0x2040): write back tag 0 (0x40), then fetch, lands in way 0
    issue("evict", C_READ, 32'h0000_2040);
    serve_mem("evict_wb", K_WB, 32'h0000_0040, 1'b0);
    serve_mem("evict_rd", K_RD, 32'h0000_2040, 1'b0);
    expect_resp("evict", 1'b0, 3'd0, 2'd2, 0, 1'b0);

    // Ranks now [0,7,6,5,4,3,2,1]: re-reading tag 0 misses and replaces way 1 (E, no write-back)
    issue("reread", C_READ, 32'h0000_0040);
    serve_mem("reread", K_RD, 32'h0000_0040, 1'b0);
    expect_resp("reread", 1'b0, 3'd1, 2'd2, 0, 1'b0);

    // Snoop read of the M line 0x1480: write-back then S
    issue("snp_rd_m", C_SNP_RD, 32'h0000_1480);
    serve_mem("snp_rd_m", K_WB, 32'h0000_1480, 1'b0);
    expect_resp("snp_rd_m", 1'b1, 3'd0, 2'd1, 0, 1'b0);

    // Snoop invalidate of E line 0xC40 (set 1 way 3): I, no traffic
    issue("snp_inv_e", C_SNP_INV, 32'h0000_0C40);
    expect_resp("snp_inv_e", 1'b1, 3'd3, 2'd0, 3, 1'b1);

    // Snoop invalidate miss (empty set 5)
    issue("snp_inv_miss", C_SNP_INV, 32'h0000_5140);
    expect_resp("snp_inv_miss", 1'b0, 3'd0, 2'd0, 3, 1'b1);

    // Clear all: accept, LOOKUP, 16 CLEAR cycles, RESP -> 19 cycles
    issue("clear", C_CLEAR, 32'h0);
    expect_resp("clear", 1'b0, 3'd0, 2'd0, 2 + SETS + 1, 1'b1);

    // After clear, 0x2040 misses into way 0
    issue("rd_after_clr", C_READ, 32'h0000_2040);
    serve_mem("rd_after_clr", K_RD, 32'h0000_2040, 1'b0);
    expect_resp("rd_after_clr", 1'b0, 3'd0, 2'd2, 0, 1'b0);

    // Reset while mem_rd is held for 0x18C0 (set 3, tag 6)
    issue("rst_mid", C_READ, 32'h0000_18C0);
    n = 0;
    while (!bus.mem_rd && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("rst_mid_rd_up", bus.mem_rd, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rd_drop", bus.mem_rd, 0);
    check("rst_mid_addr", bus.mem_addr, 0);
    check("rst_mid_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Both the interrupted address and the previously cached 0x2040 miss
    issue("rd_after_rst", C_READ, 32'h0000_18C0);
    serve_mem("rd_after_rst", K_RD, 32'h0000_18C0, 1'b0);
    expect_resp("rd_after_rst", 1'b0, 3'd0, 2'd2, 0, 1'b0);
    issue("rd2_after_rst", C_READ, 32'h0000_2040);
    serve_mem("rd2_after_rst", K_RD, 32'h0000_2040, 1'b1);
    expect_resp("rd2_after_rst", 1'b0, 3'd0, 2'd1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_set_ctrl.md
Name: cache_set_ctrl

Overview:
Parametrised, clocked N-way set-associative cache directory controller: tag/MESI/LRU storage for SETS×WAYS lines, hit lookup, true-LRU victim selection, eviction write-back and fill handshake to the next level. Successor to the combinational way-select/LRU update path. Serves either the instruction or the data cache by parameter. Sits between the trace-driven command front end and the L2 bus interface.

Parameters:
WAYS, 8, associativity; power of two, 2..16
SETS, 16384, sets; power of two
ADDR_W, 32, address width
OFFSET_W, 6, byte-offset bits (64 B line)
Derived: IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFFSET_W, WAY_W=log2(WAYS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  command present
req_ready  out  1  controller can accept a command
req_cmd  in  4  0 read, 1 write, 2 ifetch, 3 snoop invalidate, 4 snoop read, 8 clear all
req_addr  in  ADDR_W  request address
resp_valid  out  1  one-cycle completion pulse
resp_hit  out  1  request hit a valid line
resp_way  out  WAY_W  way hit or filled
resp_mesi  out  2  final line state (0 I, 1 S, 2 E, 3 M)
mem_rd  out  1  line fetch request, held until mem_ack
mem_wb  out  1  dirty-line write-back request, held until mem_ack
mem_inv  out  1  bus-upgrade request (S→M write), held until mem_ack
mem_addr  out  ADDR_W  line address for mem_*; offset bits zero
mem_ack  in  1  next level completes the outstanding request
mem_shared  in  1  sampled with mem_ack on a read fill: 1 → S, 0 → E

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; resp_valid, resp_hit, mem_rd, mem_wb, mem_inv=0; resp_way, resp_mesi, mem_addr=0; every line MESI=I, tag=0, LRU counter of way w = w.
- FSM states: IDLE, LOOKUP, WB, FETCH, UPG, RESP, CLEAR.
- IDLE: req_ready=1; a request is accepted on req_valid&req_ready; cmd, tag and index are latched → LOOKUP. req_ready=0 in every other state.
- LOOKUP (1 cycle): hit = valid way with tag match; a single match is guaranteed by construction, lowest index wins otherwise.
  - read/ifetch hit: MESI unchanged → RESP.
  - write hit: E or M → M, then RESP; S → UPG.
  - read/ifetch/write miss: victim = lowest-index way with MESI=I, else the way with LRU=WAYS-1. If victim is M → WB, else → FETCH.
  - snoop invalidate: hit M → WB, then line I; hit S/E → I; miss → RESP with resp_hit=0. No LRU update.
  - snoop read: hit M → WB, then S; hit E → S; S stays S. No LRU update.
  - clear: → CLEAR.
- WB: mem_wb=1, mem_addr={victim tag, index, 0}. On mem_ack: fills → FETCH, snoops → RESP.
- FETCH: mem_rd=1, mem_addr={req tag, index, 0}. On mem_ack the line is installed: write → M; read/ifetch → S if mem_shared else E. → RESP.
- UPG: mem_inv=1. On mem_ack the line goes S→M. → RESP.
- CLEAR: one set per cycle, index 0..SETS-1; every line I and LRU reset to way index. Then RESP with resp_hit=0.
- RESP: resp_valid=1 for exactly one cycle → IDLE.
- Latency: hit = 3 cycles from accept to resp_valid; miss adds the mem_ack wait; mem_ack in the same cycle a request first asserts is legal.
- LRU (true LRU, counters 0..WAYS-1): on any processor access to way h with old value L, ways with counter < L increment, way h → 0, others hold. Counters stay a permutation at all times. A fill counts as an access to the victim.
- mem_ack outside WB/FETCH/UPG is ignored. Only one mem_* request is asserted at a time.
- Reset mid-operation: all requests drop immediately; storage returns to its reset contents.

Optional Feature:
CACHE_STATS_EN: when defined, adds outputs stat_reads, stat_writes, stat_hits, stat_misses (32 bits each, saturating, reset to 0, cleared by cmd 8). They increment at the LOOKUP cycle of read/ifetch/write only. When undefined, these ports and their logic do not exist.

Test Plan:
- Reset, then read 0x0000_0040 → mem_rd with mem_addr 0x40; ack with shared=0 → resp_hit=0, way 0, MESI E, 3+wait cycles.
- Repeat that read → resp_hit=1, way 0, resp_valid exactly 3 cycles after accept, no mem_* activity.
- Write to the E line → M with no mem_inv. Fill a line with shared=1 and write it → mem_inv asserted, line ends M.
- Fill 9 distinct tags into set 1 (WAYS=8), first line dirty → 9th access triggers mem_wb for the first tag, then mem_rd; new line lands in way 0.
- Snoop read on an M line → mem_wb, then resp_mesi=1. Snoop invalidate on an E line → resp_mesi=0, no mem_* activity.
- Assert rst_n low while mem_rd is held → mem_rd=0 asynchronously and the next read of that address misses.
